// File: rtl/cpu_seq.sv
// rtl/cpu_seq.sv - 8-bit accumulator sequencer fetching two-byte instructions from a combinational ROM
module cpu_seq (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] adrs,
  output logic       rd,
  input  logic [7:0] din,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       halt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_OPER  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_ST   = 8'h05;
  localparam logic [7:0] OP_JMP  = 8'h06;
  localparam logic [7:0] OP_JZ   = 8'h07;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ir;
  logic [7:0] opr;
  logic [7:0] mem [0:3];
  logic       opr_in_store;
  logic [7:0] mem_val;

  // Data store occupies addresses 20..23; anything else reads as zero and ignores writes.
  assign opr_in_store = (opr[7:2] == 6'b001000);
  assign mem_val      = opr_in_store ? mem[opr[1:0]] : 8'h00;
  assign adrs         = pc;

  // State register: reset lands in FETCH so the first edge after release fetches address 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fixed three-cycle instruction, HALT opcode parks the machine until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_OPER;
      S_OPER:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (ir == OP_HALT) ? S_HALT : S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // Outputs: ROM is read in both byte-fetch cycles only.
  always_comb begin
    rd   = 1'b0;
    halt = 1'b0;
    case (state)
      S_FETCH: rd = 1'b1;
      S_OPER:  rd = 1'b1;
      S_HALT:  halt = 1'b1;
      default: begin
        rd   = 1'b0;
        halt = 1'b0;
      end
    endcase
  end

  // Datapath: latch opcode/operand during fetch, then apply the instruction in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= 8'h00;
      acc <= 8'h00;
      ir  <= 8'h00;
      opr <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      case (state)
        S_FETCH: begin
          ir <= din;
          pc <= pc + 8'h01;
        end
        S_OPER: begin
          opr <= din;
          pc  <= pc + 8'h01;
        end
        S_EXEC: begin
          case (ir)
            OP_LDI:  acc <= opr;
            OP_ADD:  acc <= acc + mem_val;
            OP_ADDI: acc <= acc + opr;
            OP_SUB:  acc <= acc - mem_val;
            OP_ST:   if (opr_in_store) mem[opr[1:0]] <= acc;
            OP_JMP:  pc <= opr;
            OP_JZ:   if (acc == 8'h00) pc <= opr;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// tb/tb_cpu_seq.sv - directed self-checking bench for cpu_seq
module tb_cpu_seq;

  logic       clk;
  logic       rst;
  logic [7:0] adrs;
  logic       rd;
  logic [7:0] din;
  logic [7:0] acc;
  logic [7:0] pc;
  logic       halt;

  logic [7:0] rom [0:255];
  int tests_run;
  int tests_failed;

  cpu_seq dut (
    .clk  (clk),
    .rst  (rst),
    .adrs (adrs),
    .rd   (rd),
    .din  (din),
    .acc  (acc),
    .pc   (pc),
    .halt (halt)
  );

  assign din = rom[adrs];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] op, input logic [7:0] arg);
    rom[a]         = op;
    rom[a + 8'h01] = arg;
  endtask

  // Hold reset across a falling edge, release it; caller is then sampling cycle 0.
  task automatic reset_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!halt && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, halt, 1'b1);
  endtask

  task automatic check_fetch_seq(input string tag, input logic [7:0] e [8]);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 40) begin
      if (rd) begin
        check(tag, adrs, e[idx]);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < 8) check({tag, "_timeout"}, idx, 8);
  endtask

  initial begin
    logic [7:0] seq_taken [8];
    logic [7:0] seq_not   [8];
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    clear_rom();

    // Reset state while rst is held
    @(negedge clk);
    check("rst_pc", pc, 8'h00);
    check("rst_acc", acc, 8'h00);
    check("rst_halt", halt, 1'b0);
    check("rst_adrs", adrs, 8'h00);
    check("rst_rd", rd, 1'b1);

    // Basic: LDI 05 / ST 20 / ADD 20 / HALT
    clear_rom();
    put(8'h00, 8'h01, 8'h05);
    put(8'h02, 8'h05, 8'h20);
    put(8'h04, 8'h02, 8'h20);
    put(8'h06, 8'h00, 8'h00);
    reset_start();
    for (int c = 0; c < 16; c++) begin
      if (c < 12) check($sformatf("basic_rd_c%0d", c), rd, (c % 3) != 2);
      if (c == 9) check("basic_acc_c9", acc, 8'h0A);
      if (c == 11) check("basic_halt_c11", halt, 1'b0);
      if (c >= 12) begin
        check($sformatf("basic_halt_c%0d", c), halt, 1'b1);
        check($sformatf("basic_adrs_c%0d", c), adrs, 8'h08);
        check($sformatf("basic_rdh_c%0d", c), rd, 1'b0);
      end
      step(1);
    end

    // Wrap arithmetic: LDI FF / ADDI 01 / SUB 21 / HALT
    clear_rom();
    put(8'h00, 8'h01, 8'hFF);
    put(8'h02, 8'h03, 8'h01);
    put(8'h04, 8'h04, 8'h21);
    put(8'h06, 8'h00, 8'h00);
    reset_start();
    step(3);
    check("wrap_ldi_ff", acc, 8'hFF);
    step(3);
    check("wrap_addi", acc, 8'h00);
    run_to_halt("wrap_a_halt", 30);
    check("wrap_sub0", acc, 8'h00);

    // Borrow wrap: LDI 01 / ST 20 / LDI 00 / SUB 20 / HALT
    clear_rom();
    put(8'h00, 8'h01, 8'h01);
    put(8'h02, 8'h05, 8'h20);
    put(8'h04, 8'h01, 8'h00);
    put(8'h06, 8'h04, 8'h20);
    put(8'h08, 8'h00, 8'h00);
    reset_start();
    step(12);
    check("wrap_sub_borrow", acc, 8'hFF);
    run_to_halt("wrap_b_halt", 30);
    check("wrap_b_pc", pc, 8'h0A);

    // Branching, taken
    seq_taken = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09, 8'h0A, 8'h0B};
    seq_not   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    clear_rom();
    put(8'h00, 8'h01, 8'h00);
    put(8'h02, 8'h07, 8'h08);
    put(8'h04, 8'h01, 8'h77);
    put(8'h06, 8'h00, 8'h00);
    put(8'h08, 8'h01, 8'h33);
    put(8'h0A, 8'h00, 8'h00);
    reset_start();
    check_fetch_seq("jz_taken_adrs", seq_taken);
    run_to_halt("jz_taken_halt", 30);
    check("jz_taken_acc", acc, 8'h33);

    // Branching, not taken
    rom[8'h01] = 8'h01;
    reset_start();
    check_fetch_seq("jz_not_adrs", seq_not);
    run_to_halt("jz_not_halt", 30);
    check("jz_not_acc", acc, 8'h77);

    // Store range
    clear_rom();
    put(8'h00, 8'h01, 8'h5A);
    put(8'h02, 8'h05, 8'h24);
    put(8'h04, 8'h05, 8'hFF);
    put(8'h06, 8'h02, 8'h24);
    put(8'h08, 8'h02, 8'h20);
    put(8'h0A, 8'h02, 8'h21);
    put(8'h0C, 8'h02, 8'h22);
    put(8'h0E, 8'h02, 8'h23);
    put(8'h10, 8'h05, 8'h23);
    put(8'h12, 8'h02, 8'h23);
    put(8'h14, 8'h00, 8'h00);
    reset_start();
    step(24);
    check("st_out_of_range", acc, 8'h5A);
    run_to_halt("st_halt", 40);
    check("st_then_add", acc, 8'hB4);

    // Reset mid-instruction: LDI 11 / LDI 99 / HALT, reset during OPER of LDI 99
    clear_rom();
    put(8'h00, 8'h01, 8'h11);
    put(8'h02, 8'h01, 8'h99);
    put(8'h04, 8'h00, 8'h00);
    reset_start();
    step(4);
    check("mid_pre_acc", acc, 8'h11);
    check("mid_pre_pc", pc, 8'h03);
    rst = 1'b1;
    #1;
    check("mid_rst_acc", acc, 8'h00);
    check("mid_rst_pc", pc, 8'h00);
    check("mid_rst_halt", halt, 1'b0);
    check("mid_rst_rd", rd, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt("mid_rerun_halt", 30);
    check("mid_rerun_acc", acc, 8'h99);
    check("mid_rerun_pc", pc, 8'h06);

    // PC wrap through a NOP at FE
    clear_rom();
    put(8'h00, 8'h01, 8'h42);
    put(8'h02, 8'h06, 8'hFE);
    rom[8'hFE] = 8'h08;
    rom[8'hFF] = 8'h55;
    reset_start();
    step(6);
    check("wrap_pc_fe", adrs, 8'hFE);
    step(1);
    check("wrap_pc_ff", adrs, 8'hFF);
    step(1);
    check("wrap_pc_00", adrs, 8'h00);
    check("wrap_pc_exec_rd", rd, 1'b0);
    step(1);
    check("wrap_fetch_adrs", adrs, 8'h00);
    check("wrap_fetch_rd", rd, 1'b1);
    check("wrap_nop_acc", acc, 8'h42);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
